// File: rtl/hazard_stall_unit_if.sv
// Pipeline-control bundle between the decode/execute datapath and the hazard stall unit.
// The datapath side drives hazard operands and consumes the enables; the unit side does the opposite.
interface hazard_stall_unit_if #(
  parameter int REG_AW = 5,
  parameter int TW     = 2,
  parameter int CNT_W  = 32
);
  logic [REG_AW-1:0] rs_D;
  logic [REG_AW-1:0] rt_D;
  logic              use_rs_D;
  logic              use_rt_D;
  logic [TW-1:0]     tuse_rs_D;
  logic [TW-1:0]     tuse_rt_D;
  logic [REG_AW-1:0] a3_E;
  logic [REG_AW-1:0] a3_M;
  logic [TW-1:0]     tnew_E;
  logic [TW-1:0]     tnew_M;
  logic              md_use_D;
  logic              md_start_E;
  logic              md_div_E;
  logic              cnt_clr;

  logic              en_pc;
  logic              en_D;
  logic              clr_E;
  logic              md_busy;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output rs_D, rt_D, use_rs_D, use_rt_D, tuse_rs_D, tuse_rt_D,
           a3_E, a3_M, tnew_E, tnew_M, md_use_D, md_start_E, md_div_E, cnt_clr,
    input  en_pc, en_D, clr_E, md_busy, stall_cnt
  );

  modport slave (
    input  rs_D, rt_D, use_rs_D, use_rt_D, tuse_rs_D, tuse_rt_D,
           a3_E, a3_M, tnew_E, tnew_M, md_use_D, md_start_E, md_div_E, cnt_clr,
    output en_pc, en_D, clr_E, md_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// Tuse/Tnew data-hazard and mult/div structural-hazard stall generator for a 5-stage pipeline,
// with a saturating counter of stalled cycles.
module hazard_stall_unit #(
  parameter int REG_AW      = 5,
  parameter int TW          = 2,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  hazard_stall_unit_if.slave bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int BW         = $clog2(MAX_CYCLES + 1);
  localparam logic [BW-1:0] MULT_LD = BW'(MULT_CYCLES);
  localparam logic [BW-1:0] DIV_LD  = BW'(DIV_CYCLES);

  logic [BW-1:0] busy_cnt;
  logic          md_busy;
  logic          stall_rs;
  logic          stall_rt;
  logic          stall_md;
  logic          stall;

  // The youngest producer (E) shadows M: if E writes the register, M's older value is irrelevant.
  function automatic logic operand_stall(
    input logic              use_op,
    input logic [REG_AW-1:0] addr,
    input logic [TW-1:0]     tuse
  );
    logic hit;
    hit = 1'b0;
    if (use_op && addr != '0) begin
      if (addr == bus.a3_E)      hit = (bus.tnew_E > tuse);
      else if (addr == bus.a3_M) hit = (bus.tnew_M > tuse);
    end
    return hit;
  endfunction

  // NOTE: every always_comb target gets a value on every path, so no latch can be inferred.
  always_comb begin
    stall_rs = operand_stall(bus.use_rs_D, bus.rs_D, bus.tuse_rs_D);
    stall_rt = operand_stall(bus.use_rt_D, bus.rt_D, bus.tuse_rt_D);
    stall_md = bus.md_use_D && (bus.md_start_E || md_busy);
    stall    = stall_rs || stall_rt || stall_md;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_cnt <= '0;
    end else if (bus.md_start_E) begin
      busy_cnt <= bus.md_div_E ? DIV_LD : MULT_LD;
    end else if (busy_cnt != '0) begin
      busy_cnt <= busy_cnt - BW'(1);
    end
  end

  assign md_busy = (busy_cnt != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.stall_cnt <= '0;
    end else if (bus.cnt_clr) begin
      bus.stall_cnt <= '0;
    end else if (stall && bus.stall_cnt != '1) begin
      bus.stall_cnt <= bus.stall_cnt + CNT_W'(1);
    end
  end

  assign bus.md_busy = md_busy;
  assign bus.en_pc   = ~stall;
  assign bus.en_D    = ~stall;
  assign bus.clr_E   = stall;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: a default instance plus a CNT_W=4 instance sharing
// the same stimulus, used to observe stall-counter saturation.
module tb_hazard_stall_unit;

  logic clk = 1'b0;
  logic reset_n;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  hazard_stall_unit_if #(.REG_AW(5), .TW(2), .CNT_W(32)) hz_if ();
  hazard_stall_unit_if #(.REG_AW(5), .TW(2), .CNT_W(4))  sat_if ();

  assign sat_if.rs_D       = hz_if.rs_D;
  assign sat_if.rt_D       = hz_if.rt_D;
  assign sat_if.use_rs_D   = hz_if.use_rs_D;
  assign sat_if.use_rt_D   = hz_if.use_rt_D;
  assign sat_if.tuse_rs_D  = hz_if.tuse_rs_D;
  assign sat_if.tuse_rt_D  = hz_if.tuse_rt_D;
  assign sat_if.a3_E       = hz_if.a3_E;
  assign sat_if.a3_M       = hz_if.a3_M;
  assign sat_if.tnew_E     = hz_if.tnew_E;
  assign sat_if.tnew_M     = hz_if.tnew_M;
  assign sat_if.md_use_D   = hz_if.md_use_D;
  assign sat_if.md_start_E = hz_if.md_start_E;
  assign sat_if.md_div_E   = hz_if.md_div_E;
  assign sat_if.cnt_clr    = hz_if.cnt_clr;

  hazard_stall_unit #(
    .REG_AW(5), .TW(2), .MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(32)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (hz_if.slave)
  );

  hazard_stall_unit #(
    .REG_AW(5), .TW(2), .MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)
  ) dut_sat (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (sat_if.slave)
  );

  task automatic set_idle();
    hz_if.rs_D       = '0;
    hz_if.rt_D       = '0;
    hz_if.use_rs_D   = 1'b0;
    hz_if.use_rt_D   = 1'b0;
    hz_if.tuse_rs_D  = '0;
    hz_if.tuse_rt_D  = '0;
    hz_if.a3_E       = '0;
    hz_if.a3_M       = '0;
    hz_if.tnew_E     = '0;
    hz_if.tnew_M     = '0;
    hz_if.md_use_D   = 1'b0;
    hz_if.md_start_E = 1'b0;
    hz_if.md_div_E   = 1'b0;
    hz_if.cnt_clr    = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    set_idle();
    #2;
    total_cnt++;
    if ({hz_if.md_busy, hz_if.stall_cnt} !== 33'd0) $display("FAIL reset_state got busy=%b cnt=%0d want 0/0", hz_if.md_busy, hz_if.stall_cnt);
    else pass_cnt++;
    total_cnt++;
    if ({hz_if.en_pc, hz_if.en_D, hz_if.clr_E} !== 3'b110) $display("FAIL reset_idle_en got %b want 110", {hz_if.en_pc, hz_if.en_D, hz_if.clr_E});
    else pass_cnt++;
    // Data hazards still stall combinationally while reset is held.
    hz_if.rs_D = 5'd8; hz_if.use_rs_D = 1'b1; hz_if.a3_E = 5'd8; hz_if.tnew_E = 2'd2;
    #1;
    total_cnt++;
    if ({hz_if.en_pc, hz_if.en_D, hz_if.clr_E} !== 3'b001) $display("FAIL reset_hazard_en got %b want 001", {hz_if.en_pc, hz_if.en_D, hz_if.clr_E});
    else pass_cnt++;
    hz_if.md_start_E = 1'b1;
    tick();
    tick();
    total_cnt++;
    if ({hz_if.md_busy, hz_if.stall_cnt, sat_if.stall_cnt} !== 37'd0) $display("FAIL reset_hold got busy=%b cnt=%0d sat=%0d want 0", hz_if.md_busy, hz_if.stall_cnt, sat_if.stall_cnt);
    else pass_cnt++;
    set_idle();
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_load_use();
    set_idle();
    hz_if.rs_D = 5'd8; hz_if.use_rs_D = 1'b1; hz_if.tuse_rs_D = 2'd0;
    hz_if.a3_E = 5'd8; hz_if.tnew_E = 2'd2;
    #1;
    total_cnt++;
    if ({hz_if.en_pc, hz_if.en_D, hz_if.clr_E} !== 3'b001) $display("FAIL load_use_E got %b want 001", {hz_if.en_pc, hz_if.en_D, hz_if.clr_E});
    else pass_cnt++;
    tick();
    hz_if.a3_E = 5'd3; hz_if.tnew_E = 2'd0; hz_if.a3_M = 5'd8; hz_if.tnew_M = 2'd1;
    #1;
    total_cnt++;
    if ({hz_if.en_pc, hz_if.en_D, hz_if.clr_E} !== 3'b001) $display("FAIL load_use_M got %b want 001", {hz_if.en_pc, hz_if.en_D, hz_if.clr_E});
    else pass_cnt++;
    tick();
    hz_if.tnew_M = 2'd0;
    #1;
    total_cnt++;
    if ({hz_if.en_pc, hz_if.en_D, hz_if.clr_E} !== 3'b110) $display("FAIL load_use_ready got %b want 110", {hz_if.en_pc, hz_if.en_D, hz_if.clr_E});
    else pass_cnt++;
    // rt path via M: stall only when tnew strictly exceeds tuse.
    set_idle();
    hz_if.rt_D = 5'd5; hz_if.use_rt_D = 1'b1; hz_if.tuse_rt_D = 2'd1;
    hz_if.a3_M = 5'd5; hz_if.tnew_M = 2'd2;
    #1;
    total_cnt++;
    if (hz_if.clr_E !== 1'b1) $display("FAIL rt_M_stall got %b want 1", hz_if.clr_E);
    else pass_cnt++;
    hz_if.tnew_M = 2'd1;
    #1;
    total_cnt++;
    if (hz_if.clr_E !== 1'b0) $display("FAIL rt_M_equal got %b want 0", hz_if.clr_E);
    else pass_cnt++;
    hz_if.tnew_M = 2'd3; hz_if.use_rt_D = 1'b0;
    #1;
    total_cnt++;
    if (hz_if.clr_E !== 1'b0) $display("FAIL rt_unused got %b want 0", hz_if.clr_E);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_priority();
    set_idle();
    hz_if.rt_D = 5'd9; hz_if.use_rt_D = 1'b1; hz_if.tuse_rt_D = 2'd1;
    hz_if.a3_E = 5'd9; hz_if.tnew_E = 2'd1; hz_if.a3_M = 5'd9; hz_if.tnew_M = 2'd2;
    #1;
    total_cnt++;
    if (hz_if.clr_E !== 1'b0) $display("FAIL prio_E_over_M got %b want 0", hz_if.clr_E);
    else pass_cnt++;
    set_idle();
    hz_if.rs_D = 5'd0; hz_if.use_rs_D = 1'b1; hz_if.a3_E = 5'd0; hz_if.tnew_E = 2'd2;
    #1;
    total_cnt++;
    if (hz_if.en_pc !== 1'b1) $display("FAIL prio_r0 got en_pc=%b want 1", hz_if.en_pc);
    else pass_cnt++;
    // Addresses differing only in the top bit must not match.
    hz_if.rs_D = 5'h11; hz_if.a3_E = 5'h01; hz_if.tnew_E = 2'd3;
    #1;
    total_cnt++;
    if (hz_if.clr_E !== 1'b0) $display("FAIL prio_full_width got %b want 0", hz_if.clr_E);
    else pass_cnt++;
    hz_if.a3_E = 5'h11;
    #1;
    total_cnt++;
    if (hz_if.clr_E !== 1'b1) $display("FAIL prio_rs_E_match got %b want 1", hz_if.clr_E);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_multiply();
    int busy_seen;
    set_idle();
    hz_if.cnt_clr = 1'b1;
    tick();
    hz_if.cnt_clr = 1'b0;
    total_cnt++;
    if (hz_if.stall_cnt !== 32'd0) $display("FAIL mult_clear got %0d want 0", hz_if.stall_cnt);
    else pass_cnt++;
    hz_if.md_use_D = 1'b1; hz_if.md_start_E = 1'b1; hz_if.md_div_E = 1'b0;
    #1;
    total_cnt++;
    if ({hz_if.clr_E, hz_if.md_busy} !== 2'b10) $display("FAIL mult_start_stall got clr_E/busy=%b want 10", {hz_if.clr_E, hz_if.md_busy});
    else pass_cnt++;
    tick();
    hz_if.md_start_E = 1'b0;
    busy_seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (hz_if.md_busy && hz_if.clr_E) busy_seen++;
      tick();
    end
    total_cnt++;
    if (busy_seen != 5) $display("FAIL mult_busy_len got %0d cycles want 5", busy_seen);
    else pass_cnt++;
    total_cnt++;
    if ({hz_if.md_busy, hz_if.clr_E} !== 2'b00) $display("FAIL mult_done got busy/clr_E=%b want 00", {hz_if.md_busy, hz_if.clr_E});
    else pass_cnt++;
    total_cnt++;
    if (hz_if.stall_cnt !== 32'd6) $display("FAIL mult_stall_cnt got %0d want 6", hz_if.stall_cnt);
    else pass_cnt++;
  endtask

  task automatic test_div_reload();
    set_idle();
    hz_if.md_start_E = 1'b1; hz_if.md_div_E = 1'b1;
    tick();
    hz_if.md_start_E = 1'b0;
    tick();
    tick();
    total_cnt++;
    if (hz_if.md_busy !== 1'b1) $display("FAIL div_busy got %b want 1", hz_if.md_busy);
    else pass_cnt++;
    hz_if.md_start_E = 1'b1; hz_if.md_div_E = 1'b0;
    tick();
    hz_if.md_start_E = 1'b0;
    for (int i = 1; i < 5; i++) begin
      tick();
      total_cnt++;
      if (hz_if.md_busy !== 1'b1) $display("FAIL div_reload_busy_%0d got %b want 1", i, hz_if.md_busy);
      else pass_cnt++;
    end
    tick();
    total_cnt++;
    if (hz_if.md_busy !== 1'b0) $display("FAIL div_reload_end got %b want 0", hz_if.md_busy);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    set_idle();
    hz_if.cnt_clr = 1'b1;
    tick();
    hz_if.cnt_clr = 1'b0;
    hz_if.rs_D = 5'd8; hz_if.use_rs_D = 1'b1; hz_if.a3_E = 5'd8; hz_if.tnew_E = 2'd2;
    for (int i = 0; i < 15; i++) tick();
    total_cnt++;
    if (sat_if.stall_cnt !== 4'hF) $display("FAIL sat_reach got %0d want 15", sat_if.stall_cnt);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) tick();
    total_cnt++;
    if (sat_if.stall_cnt !== 4'hF) $display("FAIL sat_hold got %0d want 15", sat_if.stall_cnt);
    else pass_cnt++;
    total_cnt++;
    if (hz_if.stall_cnt !== 32'd20) $display("FAIL sat_wide_cnt got %0d want 20", hz_if.stall_cnt);
    else pass_cnt++;
    hz_if.cnt_clr = 1'b1;
    tick();
    hz_if.cnt_clr = 1'b0;
    total_cnt++;
    if ({sat_if.stall_cnt, hz_if.stall_cnt, hz_if.clr_E} !== 37'd1) $display("FAIL sat_clr_prio got sat=%0d cnt=%0d clr_E=%b want 0/0/1", sat_if.stall_cnt, hz_if.stall_cnt, hz_if.clr_E);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (hz_if.stall_cnt !== 32'd1) $display("FAIL sat_resume got %0d want 1", hz_if.stall_cnt);
    else pass_cnt++;
    set_idle();
  endtask

  task automatic test_async_reset();
    set_idle();
    hz_if.md_start_E = 1'b1; hz_if.md_div_E = 1'b1;
    tick();
    hz_if.md_start_E = 1'b0;
    tick();
    tick();
    tick();
    hz_if.md_use_D = 1'b1;
    #1;
    total_cnt++;
    if ({hz_if.md_busy, hz_if.clr_E} !== 2'b11) $display("FAIL arst_pre got busy/clr_E=%b want 11", {hz_if.md_busy, hz_if.clr_E});
    else pass_cnt++;
    #2;
    reset_n = 1'b0;
    #1;
    total_cnt++;
    if ({hz_if.md_busy, hz_if.stall_cnt} !== 33'd0) $display("FAIL arst_immediate got busy=%b cnt=%0d want 0/0", hz_if.md_busy, hz_if.stall_cnt);
    else pass_cnt++;
    total_cnt++;
    if ({hz_if.en_pc, hz_if.en_D, hz_if.clr_E} !== 3'b110) $display("FAIL arst_en got %b want 110", {hz_if.en_pc, hz_if.en_D, hz_if.clr_E});
    else pass_cnt++;
    tick();
    reset_n = 1'b1;
    tick();
    total_cnt++;
    if ({hz_if.md_busy, hz_if.clr_E, hz_if.stall_cnt} !== 34'd0) $display("FAIL arst_no_persist got busy=%b clr_E=%b cnt=%0d want 0", hz_if.md_busy, hz_if.clr_E, hz_if.stall_cnt);
    else pass_cnt++;
    hz_if.md_use_D = 1'b0; hz_if.md_start_E = 1'b1; hz_if.md_div_E = 1'b0;
    tick();
    hz_if.md_start_E = 1'b0;
    total_cnt++;
    if (hz_if.md_busy !== 1'b1) $display("FAIL arst_restart got %b want 1", hz_if.md_busy);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_priority();
    test_multiply();
    test_div_reload();
    test_saturation();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/hazard_stall_unit.md
HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Parameters
REQ-001 The block SHALL have parameter REG_AW, default 5, meaning the register-address width.
REQ-002 The block SHALL have parameter TW, default 2, meaning the width of Tuse/Tnew fields.
REQ-003 The block SHALL have parameter MULT_CYCLES, default 5, meaning the multiply busy cycles (>=1).
REQ-004 The block SHALL have parameter DIV_CYCLES, default 10, meaning the divide busy cycles (>=1).
REQ-005 The block SHALL have parameter CNT_W, default 32, meaning the stall-counter width.

Interface
REQ-006 The block SHALL have one clock and an asynchronous, active-low reset: port clk (input, 1, rising-edge clock) and port reset_n (input, 1, asynchronous active-low reset).
REQ-007 The block SHALL have the following input ports:
  - rs_D, rt_D (each REG_AW): D-stage source register addresses.
  - use_rs_D, use_rt_D (each 1): D instruction reads rs/rt.
  - tuse_rs_D, tuse_rt_D (each TW): cycles until the D instruction needs rs/rt.
  - a3_E, a3_M (each REG_AW): destination register in E/M.
  - tnew_E, tnew_M (each TW): cycles until the E/M result is forwardable; 0 means ready.
  - md_use_D (1): D instruction is mult/div/mfhi/mflo/mthi/mtlo.
  - md_start_E (1): E-stage instruction is mult/div.
  - md_div_E (1): 1 selects divide, 0 selects multiply; qualifies md_start_E.
  - cnt_clr (1): synchronous clear of the stall counter.
REQ-008 The block SHALL have the following output ports:
  - en_pc, en_D (each 1): PC and IF/ID write enables.
  - clr_E (1): insert a bubble into ID/EX.
  - md_busy (1): multiply/divide unit is busy.
  - stall_cnt (CNT_W): count of stalled cycles.

Function
REQ-009 stall_rs SHALL be 1 iff use_rs_D, rs_D!=0, and either (rs_D==a3_E and tnew_E>tuse_rs_D) or (rs_D!=a3_E and rs_D==a3_M and tnew_M>tuse_rs_D).
REQ-010 stall_rt SHALL follow REQ-009 with rt_D, use_rt_D and tuse_rt_D substituted.
REQ-011 An E-stage address match SHALL take priority: when rs_D==a3_E (or rt_D==a3_E), the M comparison for that operand SHALL be ignored.
REQ-012 stall_md SHALL be 1 iff md_use_D and (md_start_E or md_busy).
REQ-013 The stall signal SHALL equal stall_rs | stall_rt | stall_md, computed combinationally in the same cycle.
REQ-014 Outputs SHALL be en_pc = ~stall, en_D = ~stall and clr_E = stall.
REQ-015 An internal busy counter of width ceil(log2(max(MULT_CYCLES,DIV_CYCLES)+1)) SHALL exist, with md_busy = (counter != 0).
REQ-016 On a clock edge with md_start_E=1, the counter SHALL load DIV_CYCLES if md_div_E=1, otherwise MULT_CYCLES; this reload SHALL occur even when the counter is nonzero.
REQ-017 On a clock edge with md_start_E=0 and counter!=0, the counter SHALL decrement by 1; at 0 it SHALL hold.
REQ-018 md_busy SHALL therefore be high for exactly N cycles following the start edge, where N is the loaded value.
REQ-019 stall_cnt SHALL increment by 1 on each clock edge where stall=1.
REQ-020 stall_cnt SHALL saturate at all-ones and never wrap.
REQ-021 cnt_clr=1 SHALL clear stall_cnt to 0 at the clock edge, taking priority over increment.
REQ-022 Address comparisons SHALL be full REG_AW bits; tnew/tuse comparisons SHALL be unsigned TW bits.

Reset
REQ-023 While reset_n=0, asynchronously: busy counter = 0, md_busy = 0, stall_cnt = 0.
REQ-024 While reset_n=0, en_pc, en_D and clr_E SHALL still follow REQ-014, with md_busy taken as 0.
REQ-025 Reset asserted mid-multiply/divide SHALL abort the operation; no stall from it SHALL persist after reset release.
REQ-026 After reset_n rises, the first clock edge SHALL operate normally.

Verification
REQ-027 Load-use: rs_D=8, use_rs_D=1, tuse_rs_D=0, a3_E=8, tnew_E=2 -> en_pc=0, en_D=0, clr_E=1; next cycle a3_M=8, tnew_M=1 -> still stalled; then tnew_M=0 -> no stall.
REQ-028 Priority: rt_D=9, tuse_rt_D=1, a3_E=9, tnew_E=1, a3_M=9, tnew_M=2 -> no stall; and rs_D=0 with a3_E=0, tnew_E=2 -> no stall.
REQ-029 Multiply: md_start_E=1, md_div_E=0 for 1 cycle -> md_busy high exactly 5 cycles; with md_use_D held at 1, stall high for 6 cycles (start cycle plus busy), and stall_cnt increases by 6.
REQ-030 Divide reload: start a divide, then assert md_start_E=1, md_div_E=0 at busy cycle 3 -> counter reloads to 5 and md_busy falls 5 cycles after the second start.
REQ-031 Counter: preload stall_cnt to all-ones with CNT_W=4 and hold stall -> stall_cnt stays 15; cnt_clr and stall in the same cycle -> 0.
REQ-032 Async reset: assert reset_n=0 between clock edges during divide busy cycle 4 -> md_busy=0 immediately and stall_cnt=0.
